// File: rtl/mem_arbiter.sv
// Shares one block-memory port between an Icache and a Dcache requester.
// Fixed Dcache priority or round-robin; each grant carries one atomic transaction.
module mem_arbiter #(
    parameter bit D_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         proc_reset,

    input  logic         i_mem_read,
    input  logic         i_mem_write,
    input  logic [27:0]  i_mem_addr,
    input  logic [127:0] i_mem_wdata,
    output logic [127:0] i_mem_rdata,
    output logic         i_mem_ready,

    input  logic         d_mem_read,
    input  logic         d_mem_write,
    input  logic [27:0]  d_mem_addr,
    input  logic [127:0] d_mem_wdata,
    output logic [127:0] d_mem_rdata,
    output logic         d_mem_ready,

    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       last_grant;
    logic       next_last_grant;
    logic       i_pending;
    logic       d_pending;

    assign i_pending = i_mem_read | i_mem_write;
    assign d_pending = d_mem_read | d_mem_write;

    // NOTE: every variable gets a default before the case, so no branch can infer a latch.
    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        case (state)
            IDLE: begin
                if (i_pending && d_pending) begin
                    if (D_FIRST || (last_grant == LG_I)) next_state = GRANT_D;
                    else                                 next_state = GRANT_I;
                end else if (d_pending) begin
                    next_state = GRANT_D;
                end else if (i_pending) begin
                    next_state = GRANT_I;
                end

                if (next_state == GRANT_I)      next_last_grant = LG_I;
                else if (next_state == GRANT_D) next_last_grant = LG_D;
            end
            GRANT_I, GRANT_D: begin
                // The grant is held until memory completes, whatever the requester does.
                if (mem_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state      <= IDLE;
            last_grant <= LG_I;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_mem_ready = 1'b0;
        d_mem_ready = 1'b0;
        case (state)
            GRANT_I: begin
                mem_read    = i_mem_read;
                mem_write   = i_mem_write;
                mem_addr    = i_mem_addr;
                mem_wdata   = i_mem_wdata;
                i_mem_ready = mem_ready;
            end
            GRANT_D: begin
                mem_read    = d_mem_read;
                mem_write   = d_mem_write;
                mem_addr    = d_mem_addr;
                mem_wdata   = d_mem_wdata;
                d_mem_ready = mem_ready;
            end
            default: ;
        endcase
    end

    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 uses fixed Dcache priority, instance 1 round-robin.
// Requester agents and a memory model drive both; a monitor checks every completed transaction.
module tb_mem_arbiter;

    localparam int MEM_LAT   = 4;
    localparam int DRAIN_MAX = 200;

    typedef struct {
        int          m;
        bit          port_d;
        bit          rd;
        bit          wr;
        logic [27:0] addr;
        logic [127:0] wd;
    } req_t;

    typedef struct {
        int          m;
        bit          port_d;
        bit          rd;
        bit          wr;
        logic [27:0] addr;
        logic [127:0] wd;
        logic [127:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic proc_reset;
    logic [1:0]         inject;

    logic [1:0]         i_rd, i_wr, i_rdy;
    logic [1:0][27:0]   i_addr;
    logic [1:0][127:0]  i_wd, i_rdata;
    logic [1:0]         d_rd, d_wr, d_rdy;
    logic [1:0][27:0]   d_addr;
    logic [1:0][127:0]  d_wd, d_rdata;
    logic [1:0]         mem_rd, mem_wr, mem_rdy;
    logic [1:0][27:0]   mem_addr;
    logic [1:0][127:0]  mem_wd, mem_rdata;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.D_FIRST(g == 0)) u_dut (
            .clk         (clk),
            .proc_reset  (proc_reset),
            .i_mem_read  (i_rd[g]),
            .i_mem_write (i_wr[g]),
            .i_mem_addr  (i_addr[g]),
            .i_mem_wdata (i_wd[g]),
            .i_mem_rdata (i_rdata[g]),
            .i_mem_ready (i_rdy[g]),
            .d_mem_read  (d_rd[g]),
            .d_mem_write (d_wr[g]),
            .d_mem_addr  (d_addr[g]),
            .d_mem_wdata (d_wd[g]),
            .d_mem_rdata (d_rdata[g]),
            .d_mem_ready (d_rdy[g]),
            .mem_read    (mem_rd[g]),
            .mem_write   (mem_wr[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wd[g]),
            .mem_rdata   (mem_rdata[g]),
            .mem_ready   (mem_rdy[g])
        );
    end

    int   checks = 0;
    int   errors = 0;
    req_t req_q[$];
    exp_t exp_q[$];
    bit   busy [2][2];
    int   done_cnt [2][2];
    int   ack_cnt [2][2];
    bit   rel_pend [2];

    task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [127:0] mem_content(input logic [27:0] addr);
        if (addr == 28'h0000010) return {16{8'hA5}};
        return {4{4'h0, addr}};
    endfunction

    function automatic bit any_busy();
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++)
                if (busy[m][p]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input int m, input int p, input bit rd, input bit wr,
                         input logic [27:0] addr, input logic [127:0] wd);
        if (p == 1) begin
            d_rd[m] = rd; d_wr[m] = wr; d_addr[m] = addr; d_wd[m] = wd;
        end else begin
            i_rd[m] = rd; i_wr[m] = wr; i_addr[m] = addr; i_wd[m] = wd;
        end
    endtask

    task automatic send(input int m, input bit port_d, input bit rd, input bit wr,
                        input logic [27:0] addr, input logic [127:0] wd);
        req_t r;
        r.m = m; r.port_d = port_d; r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd;
        req_q.push_back(r);
    endtask

    task automatic expect_txn(input int m, input bit port_d, input bit rd, input bit wr,
                              input logic [27:0] addr, input logic [127:0] wd, input logic [127:0] rdata);
        exp_t e;
        e.m = m; e.port_d = port_d; e.rd = rd; e.wr = wr; e.addr = addr; e.wd = wd; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0 || any_busy()) && n < DRAIN_MAX) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completed_in_time"}, n < DRAIN_MAX, 1'b1);
        @(negedge clk);
    endtask

    // Icache read of 0x10 issued from an idle arbiter: nothing before the edge, granted right after.
    task automatic iread_latency(input int m);
        expect_txn(m, 1'b0, 1'b1, 1'b0, 28'h0000010, '0, {16{8'hA5}});
        send(m, 1'b0, 1'b1, 1'b0, 28'h0000010, '0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("latency_before_edge_m%0d", m), {mem_rd[m], mem_wr[m]}, 2'b00);
        @(negedge clk);
        check($sformatf("latency_first_cycle_m%0d", m), {mem_rd[m], mem_wr[m], mem_addr[m]},
              {1'b1, 1'b0, 28'h0000010});
        wait_drain($sformatf("iread_m%0d", m));
    endtask

    task automatic check_outputs_zero(input string name);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s_ctrl_m%0d", name, m),
                  {mem_rd[m], mem_wr[m], i_rdy[m], d_rdy[m], mem_addr[m]}, '0);
            check($sformatf("%s_wdata_m%0d", name, m), mem_wd[m], '0);
        end
    endtask

    // Requester agents: hold strobes until the matching ready, then drop or load the next request.
    initial begin
        i_rd = '0; i_wr = '0; i_addr = '0; i_wd = '0;
        d_rd = '0; d_wr = '0; d_addr = '0; d_wd = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int m = 0; m < 2; m++) begin
                for (int p = 0; p < 2; p++) begin
                    if (busy[m][p] && done_cnt[m][p] != ack_cnt[m][p]) begin
                        ack_cnt[m][p]++;
                        busy[m][p] = 1'b0;
                        drive(m, p, 1'b0, 1'b0, '0, '0);
                    end
                    if (!busy[m][p]) begin
                        for (int k = 0; k < req_q.size(); k++) begin
                            if (req_q[k].m == m && int'(req_q[k].port_d) == p) begin
                                drive(m, p, req_q[k].rd, req_q[k].wr, req_q[k].addr, req_q[k].wd);
                                req_q.delete(k);
                                busy[m][p] = 1'b1;
                                break;
                            end
                        end
                    end
                end
            end
        end
    end

    // Memory model: completes MEM_LAT cycles after strobes appear, one-cycle ready pulse.
    initial begin
        int cnt [2];
        mem_rdy = '0;
        mem_rdata = '0;
        cnt[0] = 0;
        cnt[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (mem_rdy[m]) begin
                    mem_rdy[m] = 1'b0;
                end else if (inject[m]) begin
                    mem_rdy[m] = 1'b1;
                end else if (mem_rd[m] || mem_wr[m]) begin
                    cnt[m]++;
                    if (cnt[m] == MEM_LAT) begin
                        mem_rdy[m]   = 1'b1;
                        mem_rdata[m] = mem_content(mem_addr[m]);
                        cnt[m]       = 0;
                    end
                end else begin
                    cnt[m] = 0;
                end
            end
            @(negedge clk);
            if (proc_reset) begin
                mem_rdy = '0;
                cnt[0] = 0;
                cnt[1] = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every ready and checks the following release cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (rel_pend[m]) begin
                    check($sformatf("release_cycle_m%0d", m), {mem_rd[m], mem_wr[m]}, 2'b00);
                    rel_pend[m] = 1'b0;
                end
                if (i_rdy[m] || d_rdy[m]) begin
                    check("single_ready", i_rdy[m] & d_rdy[m], 1'b0);
                    check("ready_has_expected_txn", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("txn_instance", m, e.m);
                        check("txn_port", d_rdy[m], e.port_d);
                        check("txn_strobes", {mem_rd[m], mem_wr[m]}, {e.rd, e.wr});
                        check("txn_addr", mem_addr[m], e.addr);
                        if (e.wr) check("txn_wdata", mem_wd[m], e.wd);
                        if (e.rd) check("txn_rdata", e.port_d ? d_rdata[m] : i_rdata[m], e.rdata);
                    end
                    done_cnt[m][d_rdy[m] ? 1 : 0]++;
                    rel_pend[m] = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout expected=finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        proc_reset = 1'b1;
        inject     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        proc_reset = 1'b0;
        @(negedge clk);

        // Single Icache read on the priority instance.
        iread_latency(0);

        // Simultaneous Dcache write and Icache read, Dcache priority.
        expect_txn(0, 1'b1, 1'b0, 1'b1, 28'h0000020, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, '0);
        expect_txn(0, 1'b0, 1'b1, 1'b0, 28'h0000010, '0, {16{8'hA5}});
        send(0, 1'b1, 1'b0, 1'b1, 28'h0000020, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        send(0, 1'b0, 1'b1, 1'b0, 28'h0000010, '0);
        n = 0;
        while (!d_rdy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("prio_dwrite_first", d_rdy[0], 1'b1);
        @(negedge clk);
        check("prio_release_gap", {mem_rd[0], mem_wr[0]}, 2'b00);
        @(negedge clk);
        check("prio_iread_next", {mem_rd[0], mem_wr[0], mem_addr[0]}, {1'b1, 1'b0, 28'h0000010});
        wait_drain("prio_pair");

        // Round-robin with both requesters pending: D, I, D, I.
        expect_txn(1, 1'b1, 1'b0, 1'b1, 28'h0000200, 128'h11112222_33334444_55556666_77778888, '0);
        expect_txn(1, 1'b0, 1'b1, 1'b0, 28'h0000100, '0, 128'h00000100_00000100_00000100_00000100);
        expect_txn(1, 1'b1, 1'b1, 1'b0, 28'h0000204, '0, 128'h00000204_00000204_00000204_00000204);
        expect_txn(1, 1'b0, 1'b1, 1'b0, 28'h0000104, '0, 128'h00000104_00000104_00000104_00000104);
        send(1, 1'b1, 1'b0, 1'b1, 28'h0000200, 128'h11112222_33334444_55556666_77778888);
        send(1, 1'b1, 1'b1, 1'b0, 28'h0000204, '0);
        send(1, 1'b0, 1'b1, 1'b0, 28'h0000100, '0);
        send(1, 1'b0, 1'b1, 1'b0, 28'h0000104, '0);
        wait_drain("rr_alternate");

        // Write-back then refill with Icache pending: the Icache read slots in between.
        expect_txn(1, 1'b1, 1'b0, 1'b1, 28'h0000300, 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00, '0);
        expect_txn(1, 1'b0, 1'b1, 1'b0, 28'h0000400, '0, 128'h00000400_00000400_00000400_00000400);
        expect_txn(1, 1'b1, 1'b1, 1'b0, 28'h0000300, '0, 128'h00000300_00000300_00000300_00000300);
        send(1, 1'b1, 1'b0, 1'b1, 28'h0000300, 128'h0F0F0F0F_F0F0F0F0_00FF00FF_FF00FF00);
        send(1, 1'b1, 1'b1, 1'b0, 28'h0000300, '0);
        send(1, 1'b0, 1'b1, 1'b0, 28'h0000400, '0);
        wait_drain("rr_writeback_refill");

        // Read and write together are passed through untouched.
        expect_txn(1, 1'b0, 1'b1, 1'b1, 28'h0000600, 128'hFEDCBA98_76543210_0A0B0C0D_0E0F1011,
                   128'h00000600_00000600_00000600_00000600);
        send(1, 1'b0, 1'b1, 1'b1, 28'h0000600, 128'hFEDCBA98_76543210_0A0B0C0D_0E0F1011);
        wait_drain("read_write_conflict");

        // Stray mem_ready while idle is ignored; a following request sees normal latency.
        for (int m = 0; m < 2; m++) begin
            inject[m] = 1'b1;
            @(posedge clk);
            #3;
            inject[m] = 1'b0;
            @(negedge clk);
            check($sformatf("idle_ready_ignored_m%0d", m), {i_rdy[m], d_rdy[m], mem_rd[m], mem_wr[m]}, 4'b0000);
            @(negedge clk);
            iread_latency(m);
        end

        // Asynchronous reset in the middle of a Dcache grant.
        expect_txn(0, 1'b1, 1'b1, 1'b0, 28'h0000500, '0, 128'h00000500_00000500_00000500_00000500);
        send(0, 1'b1, 1'b1, 1'b0, 28'h0000500, '0);
        n = 0;
        while (!mem_rd[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_grant_reached", {mem_rd[0], mem_addr[0]}, {1'b1, 28'h0000500});
        @(posedge clk);
        #3;
        proc_reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        @(negedge clk);
        #2;
        proc_reset = 1'b0;
        expect_txn(0, 1'b0, 1'b1, 1'b0, 28'h0000010, '0, {16{8'hA5}});
        send(0, 1'b0, 1'b1, 1'b0, 28'h0000010, '0);
        wait_drain("after_reset");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
